apu_noise: RTL and testbench
============================

APU_NOISE -- requirements
Module: apu_noise

Interface
REQ-001 SHALL have ports: clk  input  1  system clock (CPU clock rate).
REQ-002 SHALL have ports: rst  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: apu_cycle  input  1  one-cycle pulse on every second CPU cycle.
REQ-004 SHALL have ports: qtrframe, halfframe  input  1 each  frame-counter pulses.
REQ-005 SHALL have ports: en  input  1  channel enable ($4015 bit 3).
REQ-006 SHALL have ports: reg_ctrl  input  8  $400C: [5] loop/length-halt, [4] constant volume, [3:0] volume/envelope period.
REQ-007 SHALL have ports: reg_period  input  8  $400E: [7] mode, [3:0] period index.
REQ-008 SHALL have ports: reg_length  input  8  $400F: [7:3] length index.
REQ-009 SHALL have ports: reg_ctrl_update, reg_period_update, reg_len_update  input  1 each  one-cycle pulses asserted the cycle after the register write; the register value is already valid.
REQ-010 SHALL have ports: active  output  1  length counter nonzero.
REQ-011 SHALL have ports: sample  output  4  channel output to mixer.

Function
REQ-012 SHALL hold a 15-bit LFSR; on each step: fb = lfsr[0] XOR lfsr[tap], shift right one, fb into bit 14; tap = 6 when mode=1, else 1.
REQ-013 SHALL hold an 11-bit timer decremented only on apu_cycle; when it is 0 on apu_cycle, it SHALL reload to P-1 and step the LFSR, so the LFSR steps once per P apu_cycles.
REQ-014 P by index 0..15 SHALL be: 2,4,8,16,32,48,64,80,101,127,190,254,381,508,1017,2034.
REQ-015 A period change SHALL take effect at the next timer reload; reg_period_update SHALL NOT reload the timer.
REQ-016 SHALL hold an envelope with a start flag, a 4-bit divider, and a 4-bit decay.
REQ-017 reg_len_update SHALL set the start flag.
REQ-018 On qtrframe with start set: clear start, decay=15, divider=reg_ctrl[3:0].
REQ-019 On qtrframe with start clear, when divider=0: reload divider; if decay>0 decrement decay, else if reg_ctrl[5] set decay=15.
REQ-020 On qtrframe with start clear, when divider≠0: decrement divider.
REQ-021 SHALL hold an 8-bit length counter; on reg_len_update with en=1 it SHALL load table[reg_length[7:3]].
REQ-022 Length table, indices 0..31, SHALL be: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-023 On halfframe with reg_ctrl[5]=0 and counter>0: decrement the counter.
REQ-024 reg_len_update and halfframe in the same cycle: load SHALL win, with no decrement.
REQ-025 en=0 SHALL force the length counter to 0 in the next cycle and block loads.
REQ-026 sample SHALL be registered, 1-cycle latency.
REQ-027 sample SHALL be 0 if the length counter is 0 or lfsr[0]=1; else reg_ctrl[3:0] if reg_ctrl[4]=1, else decay.
REQ-028 active SHALL equal (length counter ≠ 0), combinational from the register.

Reset
REQ-029 With rst=0 at a clk edge: lfsr=15'h0001, timer=0, length=0, start=0, divider=0, decay=0, sample=0, active=0.
REQ-030 Reset mid-operation SHALL discard all state with no partial step; the first LFSR step follows the first apu_cycle after release.

Configuration
REQ-031 Macro APU_NOISE_SHORT_MODE_EN: when defined, tap selection SHALL follow reg_period[7] per REQ-012.
REQ-032 When APU_NOISE_SHORT_MODE_EN is undefined, tap SHALL always be 1, reg_period[7] SHALL be ignored, and no mode logic SHALL be synthesized.

Verification
REQ-033 Reset release, en=1, reg_length=8'h08 (index 1) with update -> active=1, length=254; with reg_ctrl[5]=0, 254 halfframes -> active=0.
REQ-034 reg_period=8'h00, reg_ctrl=8'h1F -> LFSR steps every 2 apu_cycles; sample toggles between 0 and 15 following ~lfsr[0]; sequence repeats after 32767 steps.
REQ-035 With APU_NOISE_SHORT_MODE_EN defined, reg_period=8'h80 -> LFSR period 93 steps from seed 1; with the macro undefined -> period 32767.
REQ-036 reg_ctrl=8'h03 (envelope, period 3, no loop), length load, qtrframes -> decay 15 on the 1st, then decrements every 4th qtrframe, holds at 0.
REQ-037 reg_ctrl bit5=1: decay wraps 0->15; halfframe does not decrement length.
REQ-038 Simultaneous reg_len_update and halfframe -> length equals the table value.
REQ-039 en=0 while active -> active=0 and sample=0 on the next cycle.
REQ-040 Assert rst mid-count -> all outputs 0 and lfsr=1.

Source files
------------

// File: rtl/apu_noise.sv
// NES APU noise channel: 15-bit LFSR, envelope, length counter, registered sample.
// Define APU_NOISE_SHORT_MODE_EN to enable the short-sequence (tap 6) mode from reg_period[7].
module apu_noise (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_cycle,
  input  logic       qtrframe,
  input  logic       halfframe,
  input  logic       en,
  input  logic [7:0] reg_ctrl,
  input  logic [7:0] reg_period,
  input  logic [7:0] reg_length,
  input  logic       reg_ctrl_update,
  input  logic       reg_period_update,
  input  logic       reg_len_update,
  output logic       active,
  output logic [3:0] sample
);

  logic [14:0] lfsr_r,    lfsr_nxt_s;
  logic [10:0] timer_r,   timer_nxt_s;
  logic        start_r,   start_nxt_s;
  logic [3:0]  divider_r, divider_nxt_s;
  logic [3:0]  decay_r,   decay_nxt_s;
  logic [7:0]  length_r,  length_nxt_s;
  logic [3:0]  sample_r,  sample_nxt_s;
  logic        tap_s;
  logic        fb_s;
  logic        unused_s;

  function automatic logic [10:0] period_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    period_lut = 11'd2;
      4'd1:    period_lut = 11'd4;
      4'd2:    period_lut = 11'd8;
      4'd3:    period_lut = 11'd16;
      4'd4:    period_lut = 11'd32;
      4'd5:    period_lut = 11'd48;
      4'd6:    period_lut = 11'd64;
      4'd7:    period_lut = 11'd80;
      4'd8:    period_lut = 11'd101;
      4'd9:    period_lut = 11'd127;
      4'd10:   period_lut = 11'd190;
      4'd11:   period_lut = 11'd254;
      4'd12:   period_lut = 11'd381;
      4'd13:   period_lut = 11'd508;
      4'd14:   period_lut = 11'd1017;
      4'd15:   period_lut = 11'd2034;
      default: period_lut = 11'd2;
    endcase
  endfunction

  function automatic logic [7:0] length_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  length_lut = 8'd10;   5'd1:  length_lut = 8'd254;
      5'd2:  length_lut = 8'd20;   5'd3:  length_lut = 8'd2;
      5'd4:  length_lut = 8'd40;   5'd5:  length_lut = 8'd4;
      5'd6:  length_lut = 8'd80;   5'd7:  length_lut = 8'd6;
      5'd8:  length_lut = 8'd160;  5'd9:  length_lut = 8'd8;
      5'd10: length_lut = 8'd60;   5'd11: length_lut = 8'd10;
      5'd12: length_lut = 8'd14;   5'd13: length_lut = 8'd12;
      5'd14: length_lut = 8'd26;   5'd15: length_lut = 8'd14;
      5'd16: length_lut = 8'd12;   5'd17: length_lut = 8'd16;
      5'd18: length_lut = 8'd24;   5'd19: length_lut = 8'd18;
      5'd20: length_lut = 8'd48;   5'd21: length_lut = 8'd20;
      5'd22: length_lut = 8'd96;   5'd23: length_lut = 8'd22;
      5'd24: length_lut = 8'd192;  5'd25: length_lut = 8'd24;
      5'd26: length_lut = 8'd72;   5'd27: length_lut = 8'd26;
      5'd28: length_lut = 8'd16;   5'd29: length_lut = 8'd28;
      5'd30: length_lut = 8'd32;   5'd31: length_lut = 8'd30;
      default: length_lut = 8'd10;
    endcase
  endfunction

  // Timer and LFSR next state; the period is sampled only at reload time.
  always_comb begin
`ifdef APU_NOISE_SHORT_MODE_EN
    tap_s = reg_period[7] ? lfsr_r[6] : lfsr_r[1];
`else
    tap_s = lfsr_r[1];
`endif
    fb_s        = lfsr_r[0] ^ tap_s;
    lfsr_nxt_s  = lfsr_r;
    timer_nxt_s = timer_r;
    if (apu_cycle) begin
      if (timer_r == 11'd0) begin
        timer_nxt_s = period_lut(reg_period[3:0]) - 11'd1;
        lfsr_nxt_s  = {fb_s, lfsr_r[14:1]};
      end else begin
        timer_nxt_s = timer_r - 11'd1;
      end
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // Envelope next state; a length write re-arms the start flag even on a quarter-frame.
  always_comb begin
    start_nxt_s   = start_r | reg_len_update;
    divider_nxt_s = divider_r;
    decay_nxt_s   = decay_r;
    if (qtrframe) begin
      if (start_r) begin
        start_nxt_s   = reg_len_update;
        decay_nxt_s   = 4'd15;
        divider_nxt_s = reg_ctrl[3:0];
      end else if (divider_r == 4'd0) begin
        divider_nxt_s = reg_ctrl[3:0];
        if (decay_r != 4'd0) begin
          decay_nxt_s = decay_r - 4'd1;
        end else if (reg_ctrl[5]) begin
          decay_nxt_s = 4'd15;
        end else begin
          decay_nxt_s = decay_r;
        end
      end else begin
        divider_nxt_s = divider_r - 4'd1;
      end
    end else begin
      divider_nxt_s = divider_r;
    end
  end

  // Length counter and output sample, the sample built from post-update state.
  always_comb begin
    length_nxt_s = length_r;
    sample_nxt_s = 4'd0;
    if (!en) begin
      length_nxt_s = 8'd0;
    end else if (reg_len_update) begin
      length_nxt_s = length_lut(reg_length[7:3]);
    end else if (halfframe && !reg_ctrl[5] && (length_r != 8'd0)) begin
      length_nxt_s = length_r - 8'd1;
    end else begin
      length_nxt_s = length_r;
    end
    if ((length_nxt_s == 8'd0) || lfsr_nxt_s[0]) begin
      sample_nxt_s = 4'd0;
    end else if (reg_ctrl[4]) begin
      sample_nxt_s = reg_ctrl[3:0];
    end else begin
      sample_nxt_s = decay_nxt_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r    <= 15'h0001;
      timer_r   <= 11'd0;
      start_r   <= 1'b0;
      divider_r <= 4'd0;
      decay_r   <= 4'd0;
      length_r  <= 8'd0;
      sample_r  <= 4'd0;
    end else begin
      lfsr_r    <= lfsr_nxt_s;
      timer_r   <= timer_nxt_s;
      start_r   <= start_nxt_s;
      divider_r <= divider_nxt_s;
      decay_r   <= decay_nxt_s;
      length_r  <= length_nxt_s;
      sample_r  <= sample_nxt_s;
    end
  end

  assign active   = (length_r != 8'd0);
  assign sample   = sample_r;
  assign unused_s = ^{reg_ctrl[7:6], reg_period[7:4], reg_length[2:0],
                      reg_ctrl_update, reg_period_update};

endmodule

// File: tb/tb_apu_noise.sv
// Self-checking bench for apu_noise: behavioural model compared every cycle plus directed pins.
module tb_apu_noise;

  logic       clk = 1'b0;
  logic       rst, apu_cycle, qtrframe, halfframe, en;
  logic [7:0] reg_ctrl, reg_period, reg_length;
  logic       reg_ctrl_update, reg_period_update, reg_len_update;
  logic       active;
  logic [3:0] sample;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  int PT[16] = '{2, 4, 8, 16, 32, 48, 64, 80, 101, 127, 190, 254, 381, 508, 1017, 2034};
  int LT[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                 12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  int m_lfsr, m_wait, m_len, m_div, m_decay, m_sample;
  bit m_start;

  apu_noise dut (
    .clk(clk), .rst(rst), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
    .halfframe(halfframe), .en(en), .reg_ctrl(reg_ctrl), .reg_period(reg_period),
    .reg_length(reg_length), .reg_ctrl_update(reg_ctrl_update),
    .reg_period_update(reg_period_update), .reg_len_update(reg_len_update),
    .active(active), .sample(sample)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int l, input bit mode);
    int tap;
    int fb;
`ifdef APU_NOISE_SHORT_MODE_EN
    tap = mode ? 6 : 1;
`else
    tap = 1;
`endif
    fb = (l & 1) ^ ((l >> tap) & 1);
    return (l >> 1) | (fb << 14);
  endfunction

  function automatic int lfsr_period(input bit mode);
    int l = 1;
    for (int n = 1; n <= 40000; n++) begin
      l = lfsr_step(l, mode);
      if (l == 1) return n;
    end
    return -1;
  endfunction

  // Reference model: one call per rising edge, using inputs as they stand at that edge.
  task automatic model_step();
    if (!rst) begin
      m_lfsr = 1; m_wait = 1; m_len = 0; m_start = 0; m_div = 0; m_decay = 0; m_sample = 0;
    end else begin
      if (apu_cycle) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_lfsr = lfsr_step(m_lfsr, reg_period[7]);
          m_wait = PT[reg_period[3:0]];
        end
      end
      if (qtrframe) begin
        if (m_start) begin
          m_start = 0; m_decay = 15; m_div = reg_ctrl[3:0];
        end else if (m_div == 0) begin
          m_div = reg_ctrl[3:0];
          if (m_decay > 0) m_decay = m_decay - 1;
          else if (reg_ctrl[5]) m_decay = 15;
        end else begin
          m_div = m_div - 1;
        end
      end
      if (reg_len_update) m_start = 1;
      if (!en) m_len = 0;
      else if (reg_len_update) m_len = LT[reg_length[7:3]];
      else if (halfframe && !reg_ctrl[5] && m_len > 0) m_len = m_len - 1;
      if (m_len == 0 || (m_lfsr & 1) == 1) m_sample = 0;
      else if (reg_ctrl[4]) m_sample = reg_ctrl[3:0];
      else m_sample = m_decay;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick(input bit a, input bit q, input bit h, input bit lu);
    apu_cycle = a; qtrframe = q; halfframe = h; reg_len_update = lu;
    clk_step();
    apu_cycle = 1'b0; qtrframe = 1'b0; halfframe = 1'b0; reg_len_update = 1'b0;
  endtask

  // Per-cycle comparison of DUT against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("active", int'(active), (m_len != 0) ? 1 : 0);
      check("sample", int'(sample), m_sample);
      check("lfsr", int'(dut.lfsr_r), m_lfsr);
      check("length", int'(dut.length_r), m_len);
      check("decay", int'(dut.decay_r), m_decay);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; apu_cycle = 1'b0; qtrframe = 1'b0; halfframe = 1'b0;
    reg_ctrl = 8'h00; reg_period = 8'h00; reg_length = 8'h00;
    reg_ctrl_update = 1'b0; reg_period_update = 1'b0; reg_len_update = 1'b0;

    // Model pins: LFSR sequence lengths.
    check("lfsr_period_long", lfsr_period(1'b0), 32767);
`ifdef APU_NOISE_SHORT_MODE_EN
    check("lfsr_period_short", lfsr_period(1'b1), 93);
`else
    check("lfsr_period_mode_ignored", lfsr_period(1'b1), 32767);
`endif

    tick(0, 0, 0, 0);
    cmp_en = 1'b1;
    tick(0, 0, 0, 0);
    check("rst_active", int'(active), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_lfsr", int'(dut.lfsr_r), 1);

    // Length load, index 1.
    rst = 1'b1; en = 1'b1; reg_ctrl = 8'h1F; reg_period = 8'h00; reg_length = 8'h08;
    tick(0, 0, 0, 1);
    check("load_len254", int'(dut.length_r), 254);
    check("load_active", int'(active), 1);

    // LFSR every 2 apu_cycles, sample follows ~lfsr[0].
    tick(1, 0, 0, 0);
    check("lfsr_step1", int'(dut.lfsr_r), 15'h4000);
    check("sample_const15", int'(sample), 15);
    tick(1, 0, 0, 0);
    check("lfsr_hold", int'(dut.lfsr_r), 15'h4000);
    tick(1, 0, 0, 0);
    check("lfsr_step2", int'(dut.lfsr_r), 15'h2000);
    for (int i = 0; i < 26; i++) tick(1, 0, 0, 0);
    check("lfsr_step15", int'(dut.lfsr_r), 15'h4001);
    check("sample_lfsr1", int'(sample), 0);

    // 254 halfframes drain the counter.
    for (int i = 0; i < 253; i++) tick(0, 0, 1, 0);
    check("len_after253", int'(dut.length_r), 1);
    check("active_after253", int'(active), 1);
    tick(0, 0, 1, 0);
    check("active_after254", int'(active), 0);

    // Load wins over a simultaneous halfframe.
    tick(0, 0, 0, 1);
    reg_length = 8'h18;
    tick(0, 0, 1, 1);
    check("load_vs_half", int'(dut.length_r), 2);

    // en=0 clears on the next cycle and blocks loads.
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("lfsr_6000", int'(dut.lfsr_r), 15'h6000);
    check("sample_pre_dis", int'(sample), 15);
    en = 1'b0;
    tick(0, 0, 0, 0);
    check("dis_active", int'(active), 0);
    check("dis_sample", int'(sample), 0);
    reg_length = 8'h08;
    tick(0, 0, 0, 1);
    check("dis_load_blocked", int'(dut.length_r), 0);

    // Envelope, period 3, no loop.
    en = 1'b1; reg_ctrl = 8'h03;
    tick(0, 0, 0, 1);
    tick(0, 1, 0, 0);
    check("env_first", int'(dut.decay_r), 15);
    check("env_sample", int'(sample), 15);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    check("env_14", int'(dut.decay_r), 14);
    for (int i = 0; i < 56; i++) tick(0, 1, 0, 0);
    check("env_0", int'(dut.decay_r), 0);
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0);
    check("env_hold0", int'(dut.decay_r), 0);

    // Loop: decay wraps, halfframes leave the length alone.
    reg_ctrl = 8'h23;
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    check("env_wrap", int'(dut.decay_r), 15);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
    check("halt_len", int'(dut.length_r), 254);

    // Reset mid-count, then first step on first apu_cycle.
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    rst = 1'b0;
    tick(1, 1, 1, 0);
    check("mid_rst_active", int'(active), 0);
    check("mid_rst_sample", int'(sample), 0);
    check("mid_rst_lfsr", int'(dut.lfsr_r), 1);
    rst = 1'b1;
    tick(1, 0, 0, 0);
    check("post_rst_step", int'(dut.lfsr_r), 15'h4000);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) != 0);
      en = ($urandom_range(0, 49) != 0);
      apu_cycle = i[0];
      qtrframe = ($urandom_range(0, 5) == 0);
      halfframe = ($urandom_range(0, 9) == 0);
      reg_len_update = ($urandom_range(0, 29) == 0);
      reg_ctrl_update = 1'b0;
      reg_period_update = 1'b0;
      if ($urandom_range(0, 63) == 0) begin
        reg_ctrl = 8'($urandom);
        reg_ctrl_update = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) begin
        reg_period = {1'($urandom), 3'($urandom), 4'($urandom_range(0, 4))};
        reg_period_update = 1'b1;
      end
      if (reg_len_update) reg_length = 8'($urandom);
      clk_step();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
